// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory stage: load/store over req/ack with stall, timeout and MEM/WB register
module mem_access_stage #(
  parameter logic [3:0] OP_LOAD  = 4'b0100,
  parameter logic [3:0] OP_STORE = 4'b0101,
  parameter int         TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  opcode,
  input  logic [15:0] aluRESULT,
  input  logic [15:0] read_data2,
  input  logic [2:0]  rd,
  input  logic        reg_write,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic        wb_en,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic [3:0]  opcode_out,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  lat_op_q, lat_op_d;
  logic [2:0]  lat_rd_q, lat_rd_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic        wb_en_q, wb_en_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [3:0]  opcode_out_q, opcode_out_d;
  logic        mem_err_q, mem_err_d;

  logic is_mem;
  logic timeout_hit;
  logic completing;

  assign is_mem      = in_valid & ((opcode == OP_LOAD) | (opcode == OP_STORE));
  assign timeout_hit = (state_q == ACCESS) & ~mem_ack & (cnt_q == 8'(TIMEOUT - 1));
  assign completing  = (state_q == ACCESS) & (mem_ack | timeout_hit);
  // Dropping stall in the completing cycle lets upstream advance on that same edge.
  assign stall       = is_mem & ~completing;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_op_q     <= '0;
      lat_rd_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      opcode_out_q <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_op_q     <= lat_op_d;
      lat_rd_q     <= lat_rd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      out_valid_q  <= out_valid_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      opcode_out_q <= opcode_out_d;
      mem_err_q    <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mem) state_d = ACCESS;
      ACCESS:  if (completing) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    lat_op_d     = lat_op_q;
    lat_rd_d     = lat_rd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    out_valid_d  = 1'b0;
    wb_en_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    opcode_out_d = opcode_out_q;
    mem_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          mem_req_d   = 1'b1;
          mem_we_d    = (opcode == OP_STORE);
          mem_addr_d  = aluRESULT;
          mem_wdata_d = read_data2;
          lat_op_d    = opcode;
          lat_rd_d    = rd;
          cnt_d       = '0;
        end else if (in_valid) begin
          out_valid_d  = 1'b1;
          wb_en_d      = reg_write;
          wb_rd_d      = rd;
          wb_data_d    = aluRESULT;
          opcode_out_d = opcode;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          out_valid_d  = 1'b1;
          opcode_out_d = lat_op_q;
          if (lat_op_q == OP_LOAD) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = lat_rd_q;
            wb_data_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          mem_req_d    = 1'b0;
          out_valid_d  = 1'b1;
          mem_err_d    = 1'b1;
          opcode_out_d = lat_op_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign out_valid  = out_valid_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign opcode_out = opcode_out_q;
  assign mem_err    = mem_err_q;

endmodule
